// File: rtl/cr_xp10_decomp_be_omux_pkg.sv
// Shared types and the round-robin pick helper for the back-end output merger.
package cr_xp10_decomp_be_omux_pkg;

  localparam int OMUX_MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    DRAIN = 2'd2
  } omux_state_e;

  typedef struct packed {
    logic sot;
    logic eot;
    logic err;
  } omux_tag_t;

  // First set bit of req at or after ptr, wrapping at n; returns ptr when req is empty.
  function automatic int rr_pick(input logic [OMUX_MAX_CH-1:0] req, input int ptr, input int n);
    int   idx;
    int   sel;
    logic found;
    idx   = ptr;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < OMUX_MAX_CH; k++) begin
      if (k < n && !found && req[idx[2:0]]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx >= n - 1) ? 0 : idx + 1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_omux_if.sv
// Channel-side and outbound-side bus of the output merger.
interface cr_xp10_decomp_be_omux_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 64,
  parameter int CNT_W  = 24,
  localparam int CH_W  = $clog2(NUM_CH)
);

  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*DW-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_eot;
  logic [NUM_CH-1:0]    ch_ready;
  logic                 ob_valid;
  logic [DW-1:0]        ob_data;
  logic                 ob_sot;
  logic                 ob_eot;
  logic                 ob_err;
  logic [CH_W-1:0]      ob_ch;
  logic                 ob_ready;
  logic [CNT_W-1:0]     sw_olimit;
  logic                 olimit_evt;

  modport slave (
    input  ch_valid, ch_data, ch_eot, ob_ready, sw_olimit,
    output ch_ready, ob_valid, ob_data, ob_sot, ob_eot, ob_err, ob_ch, olimit_evt
  );

  modport master (
    output ch_valid, ch_data, ch_eot, ob_ready, sw_olimit,
    input  ch_ready, ob_valid, ob_data, ob_sot, ob_eot, ob_err, ob_ch, olimit_evt
  );

endinterface

// File: rtl/cr_xp10_decomp_be_omux_rr.sv
// Combinational round-robin pick: first requester at or after i_ptr, cyclic over NUM_CH.
module cr_xp10_decomp_be_omux_rr
  import cr_xp10_decomp_be_omux_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic              o_any,
  output logic [CH_W-1:0]   o_gnt
);

  assign o_any = |i_req;
  assign o_gnt = CH_W'(rr_pick(OMUX_MAX_CH'(i_req), int'(i_ptr), NUM_CH));

endmodule

// File: rtl/cr_xp10_decomp_be_omux.sv
// Frame-atomic round-robin merge of NUM_CH word streams onto one registered outbound stream,
// truncating frames that exceed the software word limit and draining their remainder.
module cr_xp10_decomp_be_omux
  import cr_xp10_decomp_be_omux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = 64,
  parameter int CNT_W  = 24,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  cr_xp10_decomp_be_omux_if.slave io_bus
);

  omux_state_e      r_state;
  logic [CH_W-1:0]  r_grant;
  logic [CH_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ob_valid;
  logic [DW-1:0]    r_ob_data;
  omux_tag_t        r_ob_tag;
  logic [CH_W-1:0]  r_ob_ch;
  logic             r_olimit_evt;

  logic             w_any;
  logic [CH_W-1:0]  w_pick;
  logic [CH_W-1:0]  w_next_ptr;
  logic             w_ld;
  logic             w_rdy_en;
  logic [NUM_CH-1:0] w_ch_ready;
  logic             w_acc;
  logic             w_eot_in;
  logic [DW-1:0]    w_dat_in;
  logic [CNT_W-1:0] w_n;
  logic             w_over;

  cr_xp10_decomp_be_omux_rr #(.NUM_CH(NUM_CH)) u_rr (
    .i_req (io_bus.ch_valid),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_gnt (w_pick)
  );

  // DRAIN discards, so it accepts regardless of the outbound register.
  assign w_ld       = !r_ob_valid || io_bus.ob_ready;
  assign w_rdy_en   = ((r_state == LOCK) && w_ld) || (r_state == DRAIN);
  assign w_ch_ready = w_rdy_en ? (NUM_CH'(1) << r_grant) : '0;
  assign w_acc      = |(io_bus.ch_valid & w_ch_ready);
  assign w_eot_in   = io_bus.ch_eot[r_grant];
  assign w_dat_in   = io_bus.ch_data[int'(r_grant)*DW +: DW];

  // Word number of the word being accepted; sticks at all-ones instead of wrapping.
  assign w_n        = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_over     = (io_bus.sw_olimit != '0) && (w_n > io_bus.sw_olimit);
  assign w_next_ptr = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_ob_valid   <= 1'b0;
      r_ob_data    <= '0;
      r_ob_tag     <= '0;
      r_ob_ch      <= '0;
      r_olimit_evt <= 1'b0;
    end else begin
      r_olimit_evt <= 1'b0;
      if (w_ld) begin
        r_ob_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (w_acc) begin
            r_ob_valid <= 1'b1;
            r_ob_ch    <= r_grant;
            if (w_over) begin
              // Replace the first overlimit word with a synthesized error terminator.
              r_ob_data    <= '0;
              r_ob_tag     <= '{sot: 1'b0, eot: 1'b1, err: 1'b1};
              r_olimit_evt <= 1'b1;
              if (w_eot_in) begin
                r_cnt    <= '0;
                r_rr_ptr <= w_next_ptr;
                r_state  <= IDLE;
              end else begin
                r_cnt   <= w_n;
                r_state <= DRAIN;
              end
            end else begin
              r_ob_data <= w_dat_in;
              r_ob_tag  <= '{sot: (w_n == CNT_W'(1)), eot: w_eot_in, err: 1'b0};
              if (w_eot_in) begin
                r_cnt    <= '0;
                r_rr_ptr <= w_next_ptr;
                r_state  <= IDLE;
              end else begin
                r_cnt <= w_n;
              end
            end
          end
        end
        DRAIN: begin
          if (w_acc && w_eot_in) begin
            r_cnt    <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.ch_ready   = w_ch_ready;
  assign io_bus.ob_valid   = r_ob_valid;
  assign io_bus.ob_data    = r_ob_data;
  assign io_bus.ob_sot     = r_ob_tag.sot;
  assign io_bus.ob_eot     = r_ob_tag.eot;
  assign io_bus.ob_err     = r_ob_tag.err;
  assign io_bus.ob_ch      = r_ob_ch;
  assign io_bus.olimit_evt = r_olimit_evt;

endmodule

// File: tb/tb_cr_xp10_decomp_be_omux.sv
// Directed bench for the back-end output merger: per-channel word queues feed the DUT,
// a monitor records every outbound transfer, and each scenario task checks its own results.
module tb_cr_xp10_decomp_be_omux;

  localparam int NUM_CH = 4;
  localparam int DW     = 64;
  localparam int CNT_W  = 24;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          eot;
  } sw_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sot;
    logic          eot;
    logic          err;
    logic [1:0]    ch;
  } ow_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   evt_cnt;
  sw_t  src_q[NUM_CH][$];
  ow_t  mon_q[$];

  cr_xp10_decomp_be_omux_if #(.NUM_CH(NUM_CH), .DW(DW), .CNT_W(CNT_W)) bus ();

  cr_xp10_decomp_be_omux #(.NUM_CH(NUM_CH), .DW(DW), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mkd(input int g, input int w);
    return {8'hD0, 40'h0, g[7:0], w[7:0]};
  endfunction

  function automatic ow_t mko(input logic [DW-1:0] d, input logic s, input logic e,
                              input logic r, input int g);
    ow_t o;
    o.d   = d;
    o.sot = s;
    o.eot = e;
    o.err = r;
    o.ch  = g[1:0];
    return o;
  endfunction

  // Sources: handshake seen at the falling edge, queue advanced just after the rising edge.
  initial begin
    logic [NUM_CH-1:0] fire;
    bus.ch_valid = '0;
    bus.ch_data  = '0;
    bus.ch_eot   = '0;
    forever begin
      @(negedge clk);
      fire = bus.ch_valid & bus.ch_ready;
      @(posedge clk);
      #1;
      for (int g = 0; g < NUM_CH; g++) begin
        if (fire[g] && src_q[g].size() > 0) void'(src_q[g].pop_front());
        if (src_q[g].size() > 0) begin
          bus.ch_valid[g]          = 1'b1;
          bus.ch_data[g*DW +: DW]  = src_q[g][0].d;
          bus.ch_eot[g]            = src_q[g][0].eot;
        end else begin
          bus.ch_valid[g] = 1'b0;
          bus.ch_eot[g]   = 1'b0;
        end
      end
    end
  end

  initial begin
    evt_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.ob_valid && bus.ob_ready)
        mon_q.push_back(mko(bus.ob_data, bus.ob_sot, bus.ob_eot, bus.ob_err, int'(bus.ob_ch)));
      if (bus.olimit_evt) evt_cnt++;
    end
  end

  task automatic push_frame(input int g, input int nw, input int base);
    sw_t w;
    for (int i = 1; i <= nw; i++) begin
      w.d   = mkd(g, base + i);
      w.eot = (i == nw);
      src_q[g].push_back(w);
    end
  endtask

  task automatic wait_drain(input string name);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && bus.ch_valid == '0 && !bus.ob_valid)
        quiet++;
      else
        quiet = 0;
    end
    if (quiet < 4) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s drain_timeout got %0d cycles required quiet", name, n);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int g = 0; g < NUM_CH; g++) src_q[g].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.ob_ready   = 1'b1;
    bus.sw_olimit  = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.ob_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ob_valid got %b required 0", bus.ob_valid);
    end
    tests_run++;
    if (bus.ch_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ch_ready got %b required 0000", bus.ch_ready);
    end
    tests_run++;
    if ({bus.ob_sot, bus.ob_eot, bus.ob_err, bus.olimit_evt} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b required 0000",
               {bus.ob_sot, bus.ob_eot, bus.ob_err, bus.olimit_evt});
    end
    tests_run++;
    if (bus.ob_data !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_ob_data got %h required 0", bus.ob_data);
    end
    tests_run++;
    if (bus.ob_ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_ob_ch got %0d required 0", bus.ob_ch);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    ow_t exp_q[$];
    int  k;
    mon_q.delete();
    push_frame(1, 3, 0);
    k = 0;
    while (!bus.ch_valid[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!bus.ob_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (k != 2) begin
      tests_failed++;
      $display("FAIL single_latency got %0d cycles required 2", k);
    end
    wait_drain("single");
    exp_q.push_back(mko(mkd(1, 1), 1'b1, 1'b0, 1'b0, 1));
    exp_q.push_back(mko(mkd(1, 2), 1'b0, 1'b0, 1'b0, 1));
    exp_q.push_back(mko(mkd(1, 3), 1'b0, 1'b1, 1'b0, 1));
    tests_run++;
    if (mon_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL single_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      tests_run++;
      if (mon_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL single_word[%0d] got %h required %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    ow_t exp_q[$];
    apply_reset();
    mon_q.delete();
    for (int g = 0; g < NUM_CH; g++) push_frame(g, 2, 0);
    wait_drain("rr");
    for (int g = 0; g < NUM_CH; g++)
      for (int w = 1; w <= 2; w++)
        exp_q.push_back(mko(mkd(g, w), w == 1, w == 2, 1'b0, g));
    tests_run++;
    if (mon_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rr_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      tests_run++;
      if (mon_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d] got %h required %h", i, mon_q[i], exp_q[i]);
      end
    end
    // Pointer wrapped to 0 after ch3, so ch0 wins over ch3.
    mon_q.delete();
    push_frame(3, 1, 8);
    push_frame(0, 1, 8);
    wait_drain("rr_wrap");
    tests_run++;
    if (mon_q.size() != 2 || mon_q[0].ch !== 2'd0 || mon_q[1].ch !== 2'd3) begin
      tests_failed++;
      $display("FAIL rr_wrap got n=%0d first=%0d required n=2 first=0 second=3",
               mon_q.size(), (mon_q.size() > 0) ? int'(mon_q[0].ch) : -1);
    end
  endtask

  task automatic test_olimit_trunc();
    ow_t exp_q[$];
    mon_q.delete();
    evt_cnt       = 0;
    bus.sw_olimit = 24'd2;
    push_frame(2, 5, 0);
    wait_drain("trunc");
    exp_q.push_back(mko(mkd(2, 1), 1'b1, 1'b0, 1'b0, 2));
    exp_q.push_back(mko(mkd(2, 2), 1'b0, 1'b0, 1'b0, 2));
    exp_q.push_back(mko(64'h0,     1'b0, 1'b1, 1'b1, 2));
    tests_run++;
    if (mon_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL trunc_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      tests_run++;
      if (mon_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL trunc_word[%0d] got %h required %h", i, mon_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (evt_cnt != 1) begin
      tests_failed++;
      $display("FAIL trunc_evt got %0d pulses required 1", evt_cnt);
    end
    mon_q.delete();
    push_frame(0, 1, 8);
    push_frame(3, 1, 8);
    wait_drain("trunc_next");
    tests_run++;
    if (mon_q.size() != 2 || mon_q[0].ch !== 2'd3 || mon_q[1].ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL trunc_next_grant got n=%0d first=%0d required n=2 first=3 second=0",
               mon_q.size(), (mon_q.size() > 0) ? int'(mon_q[0].ch) : -1);
    end
    bus.sw_olimit = '0;
  endtask

  task automatic test_backpressure();
    ow_t exp_q[$];
    int  k;
    mon_q.delete();
    push_frame(0, 4, 16);
    k = 0;
    while (mon_q.size() < 1 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    bus.ob_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.ob_valid, bus.ob_data, bus.ch_ready} !== {1'b1, mkd(0, 18), 4'b0000}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h rdy=%b required v=1 d=%h rdy=0000",
                 c, bus.ob_valid, bus.ob_data, bus.ch_ready, mkd(0, 18));
      end
    end
    @(posedge clk);
    #1 bus.ob_ready = 1'b1;
    wait_drain("stall");
    for (int w = 1; w <= 4; w++)
      exp_q.push_back(mko(mkd(0, 16 + w), w == 1, w == 4, 1'b0, 0));
    tests_run++;
    if (mon_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL stall_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      tests_run++;
      if (mon_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL stall_word[%0d] got %h required %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ow_t exp_q[$];
    int  k;
    mon_q.delete();
    evt_cnt = 0;
    push_frame(0, 4, 32);
    k = 0;
    while (mon_q.size() < 1 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    #1 rst_n = 1'b0;
    src_q[0].delete();
    #1;
    tests_run++;
    if ({bus.ob_valid, bus.ch_ready, bus.ob_sot, bus.ob_eot, bus.ob_err, bus.olimit_evt} !== 9'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs got v=%b rdy=%b flags=%b required all 0", bus.ob_valid,
               bus.ch_ready, {bus.ob_sot, bus.ob_eot, bus.ob_err, bus.olimit_evt});
    end
    tests_run++;
    if (bus.ob_data !== 64'h0) begin
      tests_failed++;
      $display("FAIL midrst_data got %h required 0", bus.ob_data);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_q.delete();
    bus.sw_olimit = 24'd2;
    push_frame(0, 2, 48);
    wait_drain("midrst");
    exp_q.push_back(mko(mkd(0, 49), 1'b1, 1'b0, 1'b0, 0));
    exp_q.push_back(mko(mkd(0, 50), 1'b0, 1'b1, 1'b0, 0));
    tests_run++;
    if (mon_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL midrst_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      tests_run++;
      if (mon_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL midrst_word[%0d] got %h required %h", i, mon_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (evt_cnt != 0) begin
      tests_failed++;
      $display("FAIL midrst_evt got %0d pulses required 0", evt_cnt);
    end
    bus.sw_olimit = '0;
  endtask

  task automatic test_back_to_back();
    ow_t exp_q[$];
    mon_q.delete();
    evt_cnt       = 0;
    bus.sw_olimit = 24'd1;
    push_frame(1, 1, 64);
    push_frame(1, 2, 80);
    push_frame(1, 1, 96);
    wait_drain("olimit1");
    exp_q.push_back(mko(mkd(1, 65), 1'b1, 1'b1, 1'b0, 1));
    exp_q.push_back(mko(mkd(1, 81), 1'b1, 1'b0, 1'b0, 1));
    exp_q.push_back(mko(64'h0,      1'b0, 1'b1, 1'b1, 1));
    exp_q.push_back(mko(mkd(1, 97), 1'b1, 1'b1, 1'b0, 1));
    tests_run++;
    if (mon_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL olimit1_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      tests_run++;
      if (mon_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL olimit1_word[%0d] got %h required %h", i, mon_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (evt_cnt != 1) begin
      tests_failed++;
      $display("FAIL olimit1_evt got %0d pulses required 1", evt_cnt);
    end
    bus.sw_olimit = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_olimit_trunc();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
